// File: rtl/mem_access.sv
// Memory-access pipeline stage: ALU passthrough plus a single-outstanding load/store port.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned H/W accesses into an immediate trap completion.
module mem_access (
    input  logic        clk,
    input  logic        reset,
    input  logic        valid_in,
    output logic        ready_out,
    input  logic [1:0]  mem_kind,
    input  logic [2:0]  funct3,
    input  logic [31:0] alu_result,
    input  logic [31:0] store_data,
    input  logic [5:0]  dest_in,
    input  logic [31:0] next_pc_in,
    output logic        mem_valid,
    input  logic        mem_ready,
    output logic [31:0] mem_addr,
    output logic        mem_we,
    output logic [3:0]  mem_wstrb,
    output logic [31:0] mem_wdata,
    input  logic [31:0] mem_rdata,
    output logic        valid_out,
    output logic [31:0] result,
    output logic [5:0]  dest,
`ifdef MEM_MISALIGN_TRAP_EN
    output logic        misalign,
`endif
    output logic [31:0] next_pc
);

    localparam logic IDLE = 1'b0;
    localparam logic REQ  = 1'b1;

    logic        state_q, state_d;
    logic        mem_valid_q, mem_valid_d;
    logic        mem_we_q, mem_we_d;
    logic [31:0] mem_addr_q, mem_addr_d;
    logic [3:0]  mem_wstrb_q, mem_wstrb_d;
    logic [31:0] mem_wdata_q, mem_wdata_d;
    logic        valid_out_q, valid_out_d;
    logic [31:0] result_q, result_d;
    logic [5:0]  dest_q, dest_d;
    logic [31:0] next_pc_q, next_pc_d;
    logic [1:0]  off_q, off_d;
    logic [2:0]  f3_q, f3_d;
    logic        st_q, st_d;
    logic [5:0]  pdest_q, pdest_d;
    logic [31:0] pnpc_q, pnpc_d;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign_q, misalign_d;
`endif

    logic        is_ld, is_st, sz_b, sz_h, mis;
    logic [3:0]  st_strb;
    logic [31:0] st_data;
    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign is_ld = (mem_kind == 2'b01);
    assign is_st = (mem_kind == 2'b10);
    // funct3[1:0] alone decides size; every unlisted code falls into the word case
    assign sz_b  = (funct3[1:0] == 2'b00);
    assign sz_h  = (funct3[1:0] == 2'b01);
`ifdef MEM_MISALIGN_TRAP_EN
    assign mis   = sz_h ? alu_result[0] : (!sz_b && (alu_result[1:0] != 2'b00));
`else
    assign mis   = 1'b0;
`endif

    always_comb begin
        st_strb = 4'b1111;
        st_data = store_data;
        if (sz_b) begin
            st_strb = 4'b0001 << alu_result[1:0];
            st_data = {4{store_data[7:0]}};
        end else if (sz_h) begin
            st_strb = 4'b0011 << {alu_result[1], 1'b0};
            st_data = {2{store_data[15:0]}};
        end
    end

    always_comb begin
        case (off_q)
            2'd0:    ld_byte = mem_rdata[7:0];
            2'd1:    ld_byte = mem_rdata[15:8];
            2'd2:    ld_byte = mem_rdata[23:16];
            default: ld_byte = mem_rdata[31:24];
        endcase
        ld_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        if (f3_q[1:0] == 2'b00)
            ld_val = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
        else if (f3_q[1:0] == 2'b01)
            ld_val = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
        else
            ld_val = mem_rdata;
    end

    always_comb begin
        state_d     = state_q;
        mem_valid_d = mem_valid_q;
        mem_we_d    = mem_we_q;
        mem_addr_d  = mem_addr_q;
        mem_wstrb_d = mem_wstrb_q;
        mem_wdata_d = mem_wdata_q;
        valid_out_d = 1'b0;
        result_d    = result_q;
        dest_d      = 6'd0;
        next_pc_d   = next_pc_q;
        off_d       = off_q;
        f3_d        = f3_q;
        st_d        = st_q;
        pdest_d     = pdest_q;
        pnpc_d      = pnpc_q;
`ifdef MEM_MISALIGN_TRAP_EN
        misalign_d  = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    if ((is_ld || is_st) && !mis) begin
                        off_d       = alu_result[1:0];
                        f3_d        = funct3;
                        st_d        = is_st;
                        pdest_d     = dest_in;
                        pnpc_d      = next_pc_in;
                        mem_valid_d = 1'b1;
                        mem_we_d    = is_st;
                        mem_addr_d  = {alu_result[31:2], 2'b00};
                        mem_wstrb_d = is_st ? st_strb : 4'b0000;
                        mem_wdata_d = st_data;
                        state_d     = REQ;
                    end else if (is_ld || is_st) begin
                        // trapped access completes at once with the faulting address
                        valid_out_d = 1'b1;
                        result_d    = alu_result;
                        next_pc_d   = next_pc_in;
`ifdef MEM_MISALIGN_TRAP_EN
                        misalign_d  = 1'b1;
`endif
                    end else begin
                        valid_out_d = 1'b1;
                        result_d    = alu_result;
                        dest_d      = dest_in;
                        next_pc_d   = next_pc_in;
                    end
                end
            end
            default: begin
                if (mem_ready) begin
                    mem_valid_d = 1'b0;
                    state_d     = IDLE;
                    valid_out_d = 1'b1;
                    result_d    = st_q ? 32'd0 : ld_val;
                    dest_d      = st_q ? 6'd0 : pdest_q;
                    next_pc_d   = pnpc_q;
                end
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            mem_valid_q <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= 32'd0;
            mem_wstrb_q <= 4'd0;
            mem_wdata_q <= 32'd0;
            valid_out_q <= 1'b0;
            result_q    <= 32'd0;
            dest_q      <= 6'd0;
            next_pc_q   <= 32'd0;
            off_q       <= 2'd0;
            f3_q        <= 3'd0;
            st_q        <= 1'b0;
            pdest_q     <= 6'd0;
            pnpc_q      <= 32'd0;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            mem_valid_q <= mem_valid_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wstrb_q <= mem_wstrb_d;
            mem_wdata_q <= mem_wdata_d;
            valid_out_q <= valid_out_d;
            result_q    <= result_d;
            dest_q      <= dest_d;
            next_pc_q   <= next_pc_d;
            off_q       <= off_d;
            f3_q        <= f3_d;
            st_q        <= st_d;
            pdest_q     <= pdest_d;
            pnpc_q      <= pnpc_d;
`ifdef MEM_MISALIGN_TRAP_EN
            misalign_q  <= misalign_d;
`endif
        end
    end

    assign ready_out = (state_q == IDLE);
    assign mem_valid = mem_valid_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wstrb = mem_wstrb_q;
    assign mem_wdata = mem_wdata_q;
    assign valid_out = valid_out_q;
    assign result    = result_q;
    assign dest      = dest_q;
    assign next_pc   = next_pc_q;
`ifdef MEM_MISALIGN_TRAP_EN
    assign misalign  = misalign_q;
`endif

endmodule

// File: tb/tb_mem_access.sv
// Scoreboard bench for mem_access: expected completions queued at issue, checked when valid_out fires.
module tb_mem_access;
    logic        clk = 1'b0;
    logic        reset;
    logic        valid_in, ready_out, mem_valid, mem_ready, mem_we, valid_out;
    logic [1:0]  mem_kind;
    logic [2:0]  funct3;
    logic [31:0] alu_result, store_data, next_pc_in, mem_addr, mem_wdata, mem_rdata, result, next_pc;
    logic [5:0]  dest_in, dest;
    logic [3:0]  mem_wstrb;
`ifdef MEM_MISALIGN_TRAP_EN
    logic        misalign;
`endif

    always #5 clk = ~clk;

    mem_access dut (
        .clk(clk), .reset(reset), .valid_in(valid_in), .ready_out(ready_out),
        .mem_kind(mem_kind), .funct3(funct3), .alu_result(alu_result),
        .store_data(store_data), .dest_in(dest_in), .next_pc_in(next_pc_in),
        .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
        .mem_we(mem_we), .mem_wstrb(mem_wstrb), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .valid_out(valid_out), .result(result),
        .dest(dest),
`ifdef MEM_MISALIGN_TRAP_EN
        .misalign(misalign),
`endif
        .next_pc(next_pc)
    );

    typedef struct packed {
        logic [31:0] res;
        logic [5:0]  dst;
        logic [31:0] npc;
        logic        mis;
    } exp_t;

    exp_t sbq[$];
    exp_t mon_e;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   vo_cnt  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic push(input logic [31:0] r, input logic [5:0] d, input logic [31:0] n, input logic m);
        exp_t e;
        e.res = r; e.dst = d; e.npc = n; e.mis = m;
        sbq.push_back(e);
    endtask

    always @(negedge clk) begin
        if (reset) begin
            if (valid_out) begin
                vo_cnt++;
                if (sbq.size() == 0) chk("spurious_vo", 32'd1, 32'd0);
                else begin
                    mon_e = sbq.pop_front();
                    chk("result", result, mon_e.res);
                    chk("dest", {26'd0, dest}, {26'd0, mon_e.dst});
                    chk("next_pc", next_pc, mon_e.npc);
`ifdef MEM_MISALIGN_TRAP_EN
                    chk("misalign", {31'd0, misalign}, {31'd0, mon_e.mis});
`endif
                end
            end else begin
                chk("idle_dest", {26'd0, dest}, 32'd0);
`ifdef MEM_MISALIGN_TRAP_EN
                chk("idle_misalign", {31'd0, misalign}, 32'd0);
`endif
            end
        end
    end

    task automatic nsample;
        @(negedge clk); #1;
    endtask

    task automatic drive(input logic [1:0] k, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] sd, input logic [5:0] d, input logic [31:0] n);
        chk("ready_pre", {31'd0, ready_out}, 32'd1);
        mem_kind = k; funct3 = f; alu_result = a; store_data = sd; dest_in = d; next_pc_in = n;
        valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0; mem_kind = 2'b00; alu_result = $urandom; store_data = $urandom;
    endtask

    task automatic chk_port(input string tag, input logic [31:0] addr, input logic we,
                            input logic [3:0] strb, input logic [31:0] wd, input logic chk_wd);
        chk({tag, "_mvalid"}, {31'd0, mem_valid}, 32'd1);
        chk({tag, "_addr"}, mem_addr, addr);
        chk({tag, "_we"}, {31'd0, mem_we}, {31'd0, we});
        chk({tag, "_wstrb"}, {28'd0, mem_wstrb}, {28'd0, strb});
        if (chk_wd) chk({tag, "_wdata"}, mem_wdata, wd);
        chk({tag, "_ready_lo"}, {31'd0, ready_out}, 32'd0);
    endtask

    task automatic mem_op(input string tag, input logic [1:0] k, input logic [2:0] f,
                          input logic [31:0] a, input logic [31:0] sd, input logic [5:0] d,
                          input logic [31:0] n, input logic [31:0] rd, input int waits,
                          input logic [31:0] eaddr, input logic [3:0] estrb,
                          input logic [31:0] ewd, input logic [31:0] eres);
        int v0;
        logic st;
        st = (k == 2'b10);
        push(eres, st ? 6'd0 : d, n, 1'b0);
        drive(k, f, a, sd, d, n);
        v0 = vo_cnt;
        for (int i = 0; i < waits; i++) begin
            nsample();
            chk_port({tag, "_wait"}, eaddr, st, estrb, ewd, st);
            chk({tag, "_wait_novo"}, vo_cnt - v0, 32'd0);
            @(posedge clk); #1;
        end
        mem_ready = 1'b1; mem_rdata = rd;
        nsample();
        chk_port(tag, eaddr, st, estrb, ewd, st);
        @(posedge clk); #1;
        mem_ready = 1'b0; mem_rdata = $urandom;
        nsample();
        chk({tag, "_vo_once"}, vo_cnt - v0, 32'd1);
        chk({tag, "_ready_back"}, {31'd0, ready_out}, 32'd1);
        chk({tag, "_mvalid_drop"}, {31'd0, mem_valid}, 32'd0);
    endtask

    initial begin
        int v0;
        reset = 1'b0; valid_in = 1'b0; mem_kind = 2'b00; funct3 = 3'd0; alu_result = 32'd0;
        store_data = 32'd0; dest_in = 6'd0; next_pc_in = 32'd0; mem_ready = 1'b0; mem_rdata = 32'd0;
        #2;
        chk("rst_ready", {31'd0, ready_out}, 32'd1);
        chk("rst_mvalid", {31'd0, mem_valid}, 32'd0);
        chk("rst_vo", {31'd0, valid_out}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_addr", mem_addr, 32'd0);
        chk("rst_wstrb", {28'd0, mem_wstrb}, 32'd0);
        @(negedge clk); @(negedge clk);
        reset = 1'b1;
        @(posedge clk); #1;

        // ALU passthrough, back-to-back
        v0 = vo_cnt;
        push(32'd5, 6'd1, 32'h104, 1'b0); drive(2'b00, 3'b010, 32'd5, 32'd0, 6'd1, 32'h104);
        push(32'd6, 6'd2, 32'h108, 1'b0); drive(2'b00, 3'b010, 32'd6, 32'd0, 6'd2, 32'h108);
        push(32'd7, 6'd3, 32'h10C, 1'b0); drive(2'b00, 3'b010, 32'd7, 32'd0, 6'd3, 32'h10C);
        nsample();
        chk("alu_b2b_count", vo_cnt - v0, 32'd3);
        chk("alu_ready", {31'd0, ready_out}, 32'd1);
        push(32'hAAAA_5555, 6'd9, 32'h110, 1'b0); drive(2'b11, 3'b000, 32'hAAAA_5555, 32'd0, 6'd9, 32'h110);
        nsample();

        // loads
        mem_op("lb",  2'b01, 3'b000, 32'h1003, 32'd0, 6'd4, 32'h200, 32'h80FF_FF00, 0, 32'h1000, 4'b0000, 32'd0, 32'hFFFF_FF80);
        mem_op("lbu", 2'b01, 3'b100, 32'h1003, 32'd0, 6'd5, 32'h204, 32'h80FF_FF00, 0, 32'h1000, 4'b0000, 32'd0, 32'h0000_0080);
        mem_op("lh",  2'b01, 3'b001, 32'h1002, 32'd0, 6'd6, 32'h208, 32'h80FF_FF00, 1, 32'h1000, 4'b0000, 32'd0, 32'hFFFF_80FF);
        mem_op("lhu", 2'b01, 3'b101, 32'h1000, 32'd0, 6'd7, 32'h20C, 32'h80FF_FF00, 0, 32'h1000, 4'b0000, 32'd0, 32'h0000_FF00);
        mem_op("lh0", 2'b01, 3'b001, 32'h1000, 32'd0, 6'd7, 32'h210, 32'h80FF_FF00, 0, 32'h1000, 4'b0000, 32'd0, 32'hFFFF_FF00);
        mem_op("lb1", 2'b01, 3'b000, 32'h1001, 32'd0, 6'd8, 32'h214, 32'h1234_5678, 0, 32'h1000, 4'b0000, 32'd0, 32'h0000_0056);
        mem_op("lw",  2'b01, 3'b010, 32'h1004, 32'd0, 6'd9, 32'h218, 32'hDEAD_BEEF, 0, 32'h1004, 4'b0000, 32'd0, 32'hDEAD_BEEF);
        mem_op("l011", 2'b01, 3'b011, 32'h1008, 32'd0, 6'd10, 32'h21C, 32'h8765_4321, 0, 32'h1008, 4'b0000, 32'd0, 32'h8765_4321);

        // stores
        mem_op("sh", 2'b10, 3'b001, 32'h2002, 32'h1234_ABCD, 6'd11, 32'h300, 32'd0, 0, 32'h2000, 4'b1100, 32'hABCD_ABCD, 32'd0);
        mem_op("sb", 2'b10, 3'b000, 32'h2001, 32'h0000_00A5, 6'd12, 32'h304, 32'd0, 0, 32'h2000, 4'b0010, 32'hA5A5_A5A5, 32'd0);
        mem_op("sw", 2'b10, 3'b010, 32'h2004, 32'hCAFE_F00D, 6'd13, 32'h308, 32'd0, 2, 32'h2004, 4'b1111, 32'hCAFE_F00D, 32'd0);

        // wait states
        mem_op("lw_wait", 2'b01, 3'b010, 32'h4008, 32'd0, 6'd14, 32'h400, 32'h1122_3344, 4, 32'h4008, 4'b0000, 32'd0, 32'h1122_3344);

        // misaligned word load
`ifdef MEM_MISALIGN_TRAP_EN
        push(32'h3001, 6'd0, 32'h500, 1'b1);
        drive(2'b01, 3'b010, 32'h3001, 32'd0, 6'd15, 32'h500);
        nsample();
        chk("mis_no_mvalid", {31'd0, mem_valid}, 32'd0);
        chk("mis_ready", {31'd0, ready_out}, 32'd1);
        nsample();
        chk("mis_no_mvalid2", {31'd0, mem_valid}, 32'd0);
`else
        mem_op("lw_mis", 2'b01, 3'b010, 32'h3001, 32'd0, 6'd15, 32'h500, 32'h5566_7788, 0, 32'h3000, 4'b0000, 32'd0, 32'h5566_7788);
`endif

        // mem_ready with no request outstanding
        mem_ready = 1'b1;
        repeat (3) nsample();
        mem_ready = 1'b0;

        // reset during REQ
        drive(2'b01, 3'b010, 32'h6000, 32'd0, 6'd20, 32'h600);
        nsample();
        chk("rq_mvalid", {31'd0, mem_valid}, 32'd1);
        @(posedge clk); #1;
        reset = 1'b0;
        #1;
        chk("rq_mvalid_drop", {31'd0, mem_valid}, 32'd0);
        chk("rq_vo", {31'd0, valid_out}, 32'd0);
        chk("rq_result", result, 32'd0);
        chk("rq_dest", {26'd0, dest}, 32'd0);
        chk("rq_npc", next_pc, 32'd0);
        chk("rq_addr", mem_addr, 32'd0);
        chk("rq_ready", {31'd0, ready_out}, 32'd1);
        #1 reset = 1'b1;
        v0 = vo_cnt;
        mem_ready = 1'b1; mem_rdata = 32'hFFFF_FFFF;
        repeat (3) nsample();
        mem_ready = 1'b0;
        chk("rq_no_vo", vo_cnt - v0, 32'd0);
        chk("rq_ready_after", {31'd0, ready_out}, 32'd1);

        // pipeline still works after the abandoned transaction
        mem_op("post_rst", 2'b01, 3'b100, 32'h7002, 32'd0, 6'd21, 32'h700, 32'h00C3_0000, 0, 32'h7000, 4'b0000, 32'd0, 32'h0000_00C3);

        repeat (2) nsample();
        chk("sb_empty", sbq.size(), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
